// File: rtl/bmp_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : bmp_blit_engine
// Brief    : Copies a header-prefixed image from one of NUM_IMG ROMs into
//            linear video memory at (x,y). Screen-edge clipping is compiled in
//            with the BLIT_CLIP_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module bmp_blit_engine #(
  parameter int              PIX_W   = 6,
  parameter int              SCR_W   = 640,
  parameter int              SCR_H   = 480,
  parameter int              NUM_IMG = 4,
  localparam int             IMG_W   = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
  parameter int              ROM_AW  = 16,
  parameter int              WADDR_W = 19,
  parameter logic [PIX_W-1:0] TRANSP = 6'h24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               cmd_erase,
  input  logic [IMG_W-1:0]   cmd_img,
  input  logic [9:0]         cmd_x,
  input  logic [8:0]         cmd_y,
  input  logic [PIX_W-1:0]   cmd_color,
  output logic [IMG_W-1:0]   rom_sel,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_rdata,
  output logic [WADDR_W-1:0] waddr,
  output logic [PIX_W-1:0]   wdata,
  output logic               we,
  output logic               done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HDR  = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [2:0]         r_hcnt;
  logic [9:0]         r_w;
  logic [9:0]         r_h;
  logic [9:0]         r_px;
  logic [9:0]         r_py;
  logic               r_erase;
  logic [PIX_W-1:0]   r_color;
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic [IMG_W-1:0]   r_rom_sel;
  logic [ROM_AW-1:0]  r_rom_addr;
  logic [WADDR_W-1:0] r_waddr;
  logic [PIX_W-1:0]   r_wdata;
  logic               r_we;
  logic               r_done;
  logic               r_cmd_rdy;

  logic [9:0]         w_w_shift;
  logic [9:0]         w_h_shift;
  logic [10:0]        w_cx;
  logic [9:0]         w_cy;
  logic [WADDR_W-1:0] w_lin;
  logic               w_vis;
  logic               w_opaque;
  logic               w_eol;
  logic               w_last;

  // Header halves are shifted in one word at a time; the 10-bit register
  // performs the truncation of {hi,lo} for free.
  assign w_w_shift = (r_w << PIX_W) | 10'(rom_rdata);
  assign w_h_shift = (r_h << PIX_W) | 10'(rom_rdata);

  assign w_cx   = {1'b0, r_x} + {1'b0, r_px};
  assign w_cy   = {1'b0, r_y} + r_py;
  assign w_lin  = WADDR_W'(w_cy) * WADDR_W'(SCR_W) + WADDR_W'(w_cx);

`ifdef BLIT_CLIP_EN
  assign w_vis  = (int'(w_cx) < SCR_W) && (int'(w_cy) < SCR_H);
`else
  assign w_vis  = 1'b1;
`endif

  assign w_opaque = (rom_rdata != TRANSP);
  assign w_eol    = (r_px == r_w - 10'd1);
  assign w_last   = w_eol && (r_py == r_h - 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_hcnt     <= 3'd0;
      r_w        <= 10'd0;
      r_h        <= 10'd0;
      r_px       <= 10'd0;
      r_py       <= 10'd0;
      r_erase    <= 1'b0;
      r_color    <= '0;
      r_x        <= 10'd0;
      r_y        <= 9'd0;
      r_rom_sel  <= '0;
      r_rom_addr <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_cmd_rdy  <= 1'b1;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (cmd_vld && r_cmd_rdy) begin
            r_erase    <= cmd_erase;
            r_color    <= cmd_color;
            r_x        <= cmd_x;
            r_y        <= cmd_y;
            r_rom_sel  <= cmd_img;
            r_rom_addr <= '0;
            r_hcnt     <= 3'd0;
            r_w        <= 10'd0;
            r_h        <= 10'd0;
            r_cmd_rdy  <= 1'b0;
            r_state    <= c_HDR;
          end
        end
        c_HDR: begin
          // ROM data lags the address by one cycle, so word n lands at hcnt n+1.
          r_rom_addr <= r_rom_addr + ROM_AW'(1);
          r_hcnt     <= r_hcnt + 3'd1;
          case (r_hcnt)
            3'd1, 3'd2: r_w <= w_w_shift;
            3'd3:       r_h <= w_h_shift;
            3'd4: begin
              r_h     <= w_h_shift;
              r_px    <= 10'd0;
              r_py    <= 10'd0;
              r_state <= ((r_w == 10'd0) || (w_h_shift == 10'd0)) ? c_DONE : c_RUN;
            end
            default: ;
          endcase
        end
        c_RUN: begin
          r_rom_addr <= r_rom_addr + ROM_AW'(1);
          r_we       <= w_opaque && w_vis;
          r_waddr    <= w_lin;
          r_wdata    <= r_erase ? r_color : rom_rdata;
          if (w_eol) begin
            r_px <= 10'd0;
            r_py <= r_py + 10'd1;
          end else begin
            r_px <= r_px + 10'd1;
          end
          if (w_last) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_done    <= 1'b1;
          r_cmd_rdy <= 1'b1;
          r_state   <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign cmd_rdy  = r_cmd_rdy;
  assign rom_sel  = r_rom_sel;
  assign rom_addr = r_rom_addr;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign we       = r_we;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bmp_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmp_blit_engine
// Brief    : Scoreboard bench for bmp_blit_engine with ROM models and a
//            plain-arithmetic reference (honours BLIT_CLIP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmp_blit_engine;
  localparam int PIX_W   = 6;
  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int NUM_IMG = 4;
  localparam int IMG_W   = 2;
  localparam int ROM_AW  = 16;
  localparam int WADDR_W = 19;
  localparam logic [5:0] TRANSP = 6'h24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_vld = 1'b0;
  logic               cmd_rdy;
  logic               cmd_erase = 1'b0;
  logic [IMG_W-1:0]   cmd_img = '0;
  logic [9:0]         cmd_x = '0;
  logic [8:0]         cmd_y = '0;
  logic [PIX_W-1:0]   cmd_color = '0;
  logic [IMG_W-1:0]   rom_sel;
  logic [ROM_AW-1:0]  rom_addr;
  logic [PIX_W-1:0]   rom_rdata = '0;
  logic [WADDR_W-1:0] waddr;
  logic [PIX_W-1:0]   wdata;
  logic               we;
  logic               done;

  always #5 clk = ~clk;

  bmp_blit_engine dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_erase(cmd_erase), .cmd_img(cmd_img), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_color(cmd_color), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .waddr(waddr), .wdata(wdata), .we(we), .done(done)
  );

  logic [5:0] mem [NUM_IMG][256];
  always @(posedge clk) rom_rdata <= mem[rom_sel][rom_addr[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;
  function automatic void check(input bit ok, input string name, input string msg);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wq[$];
  int  dq[$];
  int  done_seen = 0;

  always @(negedge clk) begin : mon
    wr_t e;
    int  ed;
    if (rst_n) begin
      if (we) begin
        if (wq.size() == 0) begin
          check(1'b0, "unexpected_we", $sformatf("got addr=%0d data=%0d at cyc %0d, required no write", waddr, wdata, cyc));
        end else begin
          e = wq.pop_front();
          check(cyc == e.cyc && int'(waddr) == e.addr && int'(wdata) == e.data, "write",
                $sformatf("got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                          cyc, waddr, wdata, e.cyc, e.addr, e.data));
        end
      end
      if (done) begin
        done_seen++;
        if (dq.size() == 0) begin
          check(1'b0, "unexpected_done", $sformatf("got done at cyc %0d, required none", cyc));
        end else begin
          ed = dq.pop_front();
          check(cyc == ed, "done_time", $sformatf("got cyc=%0d, required cyc=%0d", cyc, ed));
        end
      end
    end
  end

  // Reference: decode header, walk pixels row-major, apply key and clip.
  task automatic expect_cmd(input int a, input int img, input bit erase, input int x,
                            input int y, input int color, output int wh);
    int  w, h, px, py, cx, cy, p;
    bit  vis;
    wr_t e;
    w  = (int'(mem[img][0]) * (1 << PIX_W) + int'(mem[img][1])) % 1024;
    h  = (int'(mem[img][2]) * (1 << PIX_W) + int'(mem[img][3])) % 1024;
    wh = w * h;
    for (int k = 0; k < wh; k++) begin
      px = k % w;
      py = k / w;
      p  = int'(mem[img][4 + k]);
      cx = x + px;
      cy = y + py;
`ifdef BLIT_CLIP_EN
      vis = (cx < SCR_W) && (cy < SCR_H);
`else
      vis = 1'b1;
`endif
      if (p != int'(TRANSP) && vis) begin
        e.cyc  = a + 6 + k;
        e.addr = (cy * SCR_W + cx) % (1 << WADDR_W);
        e.data = erase ? color : p;
        wq.push_back(e);
      end
    end
    dq.push_back(a + 6 + wh);
  endtask

  task automatic set_hdr(input int img, input int w, input int h, input int junk);
    mem[img][0] = 6'((w >> 6) | ((junk & 3) << 4));
    mem[img][1] = 6'(w & 63);
    mem[img][2] = 6'(h >> 6);
    mem[img][3] = 6'(h & 63);
  endtask

  task automatic issue(input bit erase, input int img, input int x, input int y, input int color,
                       input bit hold, output int a, output int wh);
    bit r;
    bit got;
    int n;
    @(negedge clk);
    cmd_erase = erase;
    cmd_img   = IMG_W'(img);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_color = 6'(color);
    cmd_vld   = 1'b1;
    got = 1'b0;
    n   = 0;
    a   = -1;
    wh  = 0;
    while (!got && n < 300) begin
      r = cmd_rdy;
      @(negedge clk);
      n++;
      got = r;
    end
    if (!hold) cmd_vld = 1'b0;
    check(got, "accept", $sformatf("got no accept after %0d cycles, required accept", n));
    if (got) begin
      a = cyc;
      check(cmd_rdy == 1'b0, "rdy_drop", $sformatf("got cmd_rdy=%0b after accept, required 0", cmd_rdy));
      expect_cmd(a, img, erase, x, y, color, wh);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0 || !cmd_rdy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(n < 600, "drain", $sformatf("got %0d writes and %0d dones outstanding, required 0", wq.size(), dq.size()));
    wq.delete();
    dq.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion by 1ms, required finish");
    $fatal(1);
  end

  initial begin
    int a, a2, wh, wh2, seen, w, h, x, y;
    for (int i = 0; i < NUM_IMG; i++)
      for (int j = 0; j < 256; j++) mem[i][j] = 6'd0;
    repeat (3) @(negedge clk);
    check(cmd_rdy == 1'b1, "rst_rdy", $sformatf("got %0b, required 1", cmd_rdy));
    check(we == 1'b0 && done == 1'b0, "rst_we_done", $sformatf("got we=%0b done=%0b, required 0/0", we, done));
    check(waddr == '0 && wdata == '0, "rst_wbus", $sformatf("got waddr=%0d wdata=%0d, required 0/0", waddr, wdata));
    check(rom_addr == '0 && rom_sel == '0, "rst_rom", $sformatf("got rom_addr=%0d rom_sel=%0d, required 0/0", rom_addr, rom_sel));
    @(posedge clk);
    #2 rst_n = 1'b1;

    set_hdr(1, 4, 2, 0);
    for (int k = 0; k < 8; k++) mem[1][4 + k] = 6'(k + 1);
    issue(1'b0, 1, 10, 5, 0, 1'b0, a, wh);
    wait_idle();
    issue(1'b1, 1, 10, 5, 0, 1'b0, a, wh);
    wait_idle();

    set_hdr(2, 3, 1, 1);
    mem[2][4] = 6'd3;
    mem[2][5] = TRANSP;
    mem[2][6] = 6'd7;
    issue(1'b0, 2, 100, 200, 0, 1'b0, a, wh);
    wait_idle();

    set_hdr(3, 4, 1, 0);
    for (int k = 0; k < 4; k++) mem[3][4 + k] = 6'(9 + k);
    issue(1'b0, 3, 638, 0, 0, 1'b0, a, wh);
    wait_idle();

    // width header {0x10,0} truncates to zero
    set_hdr(0, 0, 3, 1);
    issue(1'b0, 0, 50, 50, 0, 1'b0, a, wh);
    wait_idle();

    set_hdr(0, 1, 1, 0);
    mem[0][4] = 6'd5;
    set_hdr(3, 1, 1, 0);
    mem[3][4] = 6'd17;
    issue(1'b0, 0, 1, 1, 0, 1'b1, a, wh);
    issue(1'b1, 3, 2, 2, 33, 1'b0, a2, wh2);
    check(a2 == a + 7 + wh, "b2b_accept", $sformatf("got accept at %0d, required %0d", a2, a + 7 + wh));
    wait_idle();

    set_hdr(1, 6, 4, 0);
    for (int k = 0; k < 24; k++) mem[1][4 + k] = 6'(k + 40);
    issue(1'b0, 1, 20, 30, 0, 1'b0, a, wh);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    wq.delete();
    dq.delete();
    @(negedge clk);
    check(we == 1'b0 && cmd_rdy == 1'b1 && done == 1'b0, "mid_reset",
          $sformatf("got we=%0b cmd_rdy=%0b done=%0b, required 0/1/0", we, cmd_rdy, done));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = done_seen;
    repeat (40) @(negedge clk);
    check(done_seen == seen, "no_done_after_reset", $sformatf("got %0d dones, required 0", done_seen - seen));

    for (int t = 0; t < 30; t++) begin
      int img;
      img = int'($urandom_range(0, 3));
      w   = int'($urandom_range(1, 6));
      h   = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) w = 0;
      set_hdr(img, w, h, int'($urandom_range(0, 3)));
      for (int k = 0; k < 24; k++)
        mem[img][4 + k] = ($urandom_range(0, 3) == 0) ? TRANSP : 6'($urandom_range(0, 63));
      x = ($urandom_range(0, 2) == 0) ? int'($urandom_range(630, 639)) : int'($urandom_range(0, 600));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(475, 511)) : int'($urandom_range(0, 470));
      issue(1'($urandom_range(0, 1)), img, x, y, int'($urandom_range(0, 63)), 1'b0, a, wh);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bmp_blit_engine.md
# bmp_blit_engine

Parametrised bitmap blitter that copies a header-prefixed image from one of `NUM_IMG` synchronous image ROMs into linear video memory at a commanded (x,y) location. It replaces the fixed-width single-mode placer with a valid/ready command port, an erase mode, and configurable pixel width, screen geometry and ROM count, and it clips at the screen edges. It sits between the CPU-side command decoder and the videoMem write port.

## Interface
Parameters:
- `PIX_W`, 6: pixel width in bits; also the ROM word width.
- `SCR_W`, 640: screen width in pixels.
- `SCR_H`, 480: screen height in pixels.
- `NUM_IMG`, 4: number of image ROMs; `IMG_W` = max(1, $clog2(NUM_IMG)).
- `ROM_AW`, 16: ROM address width.
- `WADDR_W`, 19: video memory address width.
- `TRANSP`, 6'h24: transparent colour key, PIX_W bits.

Ports (reset is `rst_n`, asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  engine idle and able to accept a command.
- `cmd_erase`  in  1  0 = draw image pixels, 1 = write `cmd_color` at opaque pixels.
- `cmd_img`  in  IMG_W  ROM select.
- `cmd_x`  in  10  left column.
- `cmd_y`  in  9  top row.
- `cmd_color`  in  PIX_W  erase colour.
- `rom_sel`  out  IMG_W  registered copy of `cmd_img`.
- `rom_addr`  out  ROM_AW  ROM read address.
- `rom_rdata`  in  PIX_W  ROM data, valid one cycle after `rom_addr`.
- `waddr`  out  WADDR_W  video memory write address.
- `wdata`  out  PIX_W  video memory write data.
- `we`  out  1  video memory write strobe.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- Reset values: `cmd_rdy`=1, `rom_addr`=0, `rom_sel`=0, `waddr`=0, `wdata`=0, `we`=0, `done`=0. FSM starts in IDLE.
- ROM image format:
  - word0 = width high, word1 = width low, word2 = height high, word3 = height low.
  - W = {w0,w1} and H = {w2,w3}, each truncated to 10 bits.
  - Pixels are row-major starting at word 4.
- FSM states: IDLE → HDR → RUN → DONE → IDLE.
- IDLE: `cmd_rdy`=1. On `cmd_vld && cmd_rdy`, latch the command, set `rom_addr`=0, and go to HDR. `cmd_rdy` drops the next cycle.
- HDR: present addresses 0..3 and capture the four header words as they return.
  - Set pixel counters px=0, py=0.
  - If W==0 or H==0, go to DONE with no writes; otherwise go to RUN.
- RUN: one ROM read per cycle, addresses 4 .. 3+W*H.
  - Each returned pixel p at counters (px,py) gives target column cx = cmd_x+px and row cy = cmd_y+py.
  - `waddr` = cy*SCR_W + cx, computed at WADDR_W bits.
  - `we`=1 only when p != TRANSP and the pixel survives clipping.
  - `wdata` = `cmd_erase` ? `cmd_color` : p.
  - Counter update: px increments; when px == W-1, px wraps to 0 and py increments.
  - After the pixel (W-1,H-1) is written, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `cmd_vld` is ignored while `cmd_rdy`=0; commands are never queued.
- `rst_n` asserted mid-command aborts immediately: all outputs return to reset values, with no further `we` and no `done`.
- Arithmetic: cx and cy use 11-bit and 10-bit sums, so no wrap occurs before the clip compare.

## Timing
- Let A be the accept edge.
- ROM addresses 0..3 are presented in cycles A+1..A+4.
- First pixel address is presented at A+5; the first possible `we` is at A+6.
- Pixel k (0-based) is written at A+6+k, so the last write is at A+5+W*H.
- `done` is asserted at A+6+W*H. `cmd_rdy` returns to 1 at A+7+W*H, so the next command can be accepted on that edge.
- With W==0 or H==0, `done` is asserted at A+6.
- `we`, `waddr` and `wdata` are registered and change together.

## Configuration
- `BLIT_CLIP_EN` defined: a pixel with cx ≥ SCR_W or cy ≥ SCR_H has `we` forced to 0. The ROM address and counters still advance, so timing is unchanged.
- `BLIT_CLIP_EN` undefined: no clip compare. `waddr` = (cy*SCR_W + cx) mod 2^WADDR_W, so off-screen columns spill onto the next row.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN → `we`=0 and `cmd_rdy`=1 while in reset; no `done` follows after release.
- Draw: 4×2 image on ROM1 with pixels 1..8, at x=10, y=5 → 8 writes at `waddr` 3210..3213 and 3850..3853 with data 1..8, first write at A+6, `done` at A+14.
- Transparency: image with pixels {3, 6'h24, 7} → writes only at offsets 0 and 2, `done` timing unchanged.
- Erase: same 4×2 image, `cmd_erase`=1, `cmd_color`=0 → 8 writes of 0 at the same addresses.
- Clip (`BLIT_CLIP_EN`): 4×1 image at x=638, y=0 → writes only at 638 and 639, `done` at A+10. Without the macro → writes at 638..641.
- Handshake: hold `cmd_vld`=1 continuously for two 1×1 commands → second accepted at A+8. Zero-size header → no `we`, `done` at A+6.
